// File: rtl/score_pkg.sv
// Shared definitions for the score path: widths, BCD conversion FSM states
// and active-low seven-segment codes ({g,f,e,d,c,b,a}).
package score_pkg;

  localparam int NUM_DIGITS = 3;
  localparam int SCORE_W    = 7;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Double-dabble correction: any nibble >= 5 gets +3 before the next shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_display_if.sv
// Bundle between the score source and the display block.
// No handshake: score is sampled as a level every cycle; the outputs are plain registered levels.
interface score_display_if;
  import score_pkg::*;

  logic [SCORE_W-1:0] score;
  logic [3:0]         an;
  logic [6:0]         seg;
  logic [BCD_W-1:0]   bcd;
  logic               busy;
  state_t             state;

  modport master (output score, input an, seg, bcd, busy, state);
  modport slave  (input score, output an, seg, bcd, busy, state);

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low seven-segment decoder; non-decimal
// nibbles produce a blank digit.
module seg7_decode
  import score_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// Score to 3-digit BCD (double dabble FSM) and a multiplexed 4-digit active-low display.
// Define SCORE_DISP_LZB_EN to blank leading zeros on the hundreds/tens digits.
module score_display
  import score_pkg::*;
#(
  parameter int SCAN_BITS = 18
) (
  input  logic            clk,
  input  logic            rst,
  score_display_if.slave  sif
);

  state_t             state_q,   state_d;
  logic               busy_q,    busy_d;
  logic [SCORE_W-1:0] last_q,    last_d;
  logic [SCORE_W-1:0] shreg_q,   shreg_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [2:0]         bitcnt_q,  bitcnt_d;
  logic [BCD_W-1:0]   bcd_q,     bcd_d;
  logic [SCAN_BITS-1:0] scan_q,  scan_d;
  logic [3:0]         an_q,      an_d;
  logic [6:0]         seg_q,     seg_d;

  logic [BCD_W-1:0]   adj;
  logic [1:0]         digit;
  logic [3:0]         nib;
  logic [6:0]         seg_dec;
  logic               blank;

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    last_d    = last_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    bitcnt_d  = bitcnt_q;
    bcd_d     = bcd_q;
    adj       = dabble_adjust(scratch_q);
    case (state_q)
      ST_IDLE: begin
        if (sif.score != last_q) begin
          last_d    = sif.score;
          shreg_d   = sif.score;
          scratch_d = '0;
          bitcnt_d  = '0;
          state_d   = ST_SHIFT;
          busy_d    = 1'b1;
        end
      end
      ST_SHIFT: begin
        {scratch_d, shreg_d} = {adj, shreg_q} << 1;
        if (bitcnt_q == 3'd6) state_d = ST_DONE;
        else                  bitcnt_d = bitcnt_q + 3'd1;
      end
      ST_DONE: begin
        bcd_d   = scratch_q;
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Scan path works from this cycle's counter and bcd, so the pins lag by one cycle.
  assign digit = scan_q[SCAN_BITS-1 -: 2];

  always_comb begin
    case (digit)
      2'd0:    nib = bcd_q[3:0];
      2'd1:    nib = bcd_q[7:4];
      2'd2:    nib = bcd_q[11:8];
      default: nib = 4'd0;
    endcase
  end

  seg7_decode u_dec (
    .nib (nib),
    .seg (seg_dec)
  );

  always_comb begin
`ifdef SCORE_DISP_LZB_EN
    blank = (digit == 2'd3) ||
            (digit == 2'd2 && bcd_q[11:8] == 4'd0) ||
            (digit == 2'd1 && bcd_q[11:4] == 8'd0);
`else
    blank = (digit == 2'd3);
`endif
    scan_d = scan_q + SCAN_BITS'(1);
    an_d   = 4'b1111;
    seg_d  = SEG_BLANK;
    if (!blank) begin
      an_d[digit] = 1'b0;
      seg_d       = seg_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      last_q    <= '0;
      shreg_q   <= '0;
      scratch_q <= '0;
      bitcnt_q  <= '0;
      bcd_q     <= '0;
      scan_q    <= '0;
      an_q      <= 4'b1111;
      seg_q     <= SEG_BLANK;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      last_q    <= last_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      bitcnt_q  <= bitcnt_d;
      bcd_q     <= bcd_d;
      scan_q    <= scan_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign sif.an    = an_q;
  assign sif.seg   = seg_q;
  assign sif.bcd   = bcd_q;
  assign sif.busy  = busy_q;
  assign sif.state = state_q;

endmodule

// File: doc/score_display.md
# score_display

Converts the 7-bit game score into three BCD digits and drives a time-multiplexed 4-digit active-low seven-segment display. It sits directly downstream of `score`: it consumes `score[6:0]` and feeds the board anode and segment pins. Binary-to-BCD conversion is a multi-cycle double-dabble state machine, re-triggered whenever the input score changes. Digit scanning is a free-running refresh counter.

## Interface
- `SCAN_BITS`, 18: refresh counter width. The top 2 bits select the active digit, so each digit is lit for 2^(SCAN_BITS-2) cycles. Minimum value is 3.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `score`  in  7  unsigned score, 0..127; may change on any cycle.
- `an`  out  4  digit anodes, active-low, registered. Bit 0 is the ones digit.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- `bcd`  out  12  committed BCD value {hundreds, tens, ones}.
- `busy`  out  1  high while a conversion is in progress.

## Operation
- Reset values:
  - `an`=4'b1111, `seg`=7'b1111111, `bcd`=12'h000, `busy`=0.
  - Refresh counter = 0, `last_score` = 0, state IDLE.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If `score != last_score`, capture `score` into the shift register and into `last_score`.
  - Clear the BCD scratch register and the bit counter, then go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - Each cycle, add 3 to every scratch BCD nibble that is ≥5, then shift {scratch, shift reg} left by 1.
  - After exactly 7 shifts, go to DONE.
- DONE: copy scratch to `bcd`, then go to IDLE.
- `busy` = (state != IDLE).
- Changes to `score` while busy are ignored until the next IDLE. Only the captured value completes, and the mismatch is then detected and converted next.
- Width rules:
  - Scratch register is 12 bits, so 127 maps to 12'h127 with no overflow.
  - Values above 199 are impossible because the input is 7 bits.
- Scan:
  - Refresh counter increments every cycle and wraps at 2^SCAN_BITS.
  - Digit index d = counter[SCAN_BITS-1:SCAN_BITS-2].
  - d=0,1,2 → `an` has bit d low, and `seg` = decode of `bcd` nibble d.
  - d=3 → `an`=4'b1111 and `seg`=7'b1111111 (unused digit).
- Segment codes:
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001
  - 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000
  - Other nibble values → 1111111.
- `rst` mid-conversion: abort to IDLE and clear `bcd` and `last_score`. If `score` is nonzero, a fresh conversion starts on the first post-reset edge.

## Timing
- Score-change latency: `score` stable before edge E.
  - Captured at E, with `busy` high after E.
  - Seven SHIFT edges, E+1 .. E+7.
  - DONE at E+8: `bcd` updates and `busy` falls after E+8.
- Back-to-back changes: the minimum restart is E+9.
- `an`/`seg` are registered. They reflect the counter and `bcd` values from the previous cycle, so a `bcd` update appears on the pins one cycle later while its digit is selected.
- No handshake on `score`; the block samples the level.

## Configuration
- `SCORE_DISP_LZB_EN` defined: leading-zero blanking.
  - Hundreds digit is blank when its value is 0.
  - Tens digit is blank when hundreds and tens are both 0.
  - Ones digit is always shown, so score 0 displays "0".
  - `an` for a blanked digit stays 1.
- Undefined: all three digits are always shown, e.g. "007".
- The macro does not affect `bcd` or FSM timing.

## Structure
- Shared package `score_pkg`:
  - FSM state encoding.
  - The ten segment constants plus SEG_BLANK.
  - NUM_DIGITS=3 and SCORE_W=7, so these are shared with `score`.
- Sub-module `seg7_decode`: combinational 4-bit → 7-bit active-low decoder, instantiated once on the muxed nibble.

## Test plan
- Reset with `score`=0: `bcd`=12'h000, `busy` never rises, and `seg` shows 1000000 on ones.
- With `SCAN_BITS`=4: `an` sequence is 1110, 1101, 1011, 1111, each held 4 cycles, then wraps.
- `score` 0→127 at edge E: `busy` high E..E+8, `bcd`=12'h127 after E+8, and the hundreds digit shows 1111001.
- `score`=45, then 99 at E+3: `bcd`=12'h045 after E+8, then 12'h099 after E+17.
- `rst` pulsed at E+4 of a conversion of 88: `bcd`=0 and `busy`=0 after reset, then `bcd`=12'h088 nine cycles after release.
- `score`=7:
  - With `SCORE_DISP_LZB_EN`: hundreds and tens show `an`=1 and `seg`=1111111.
  - Without it: both show 1000000.
